// File: rtl/sccb_slave_responder.sv
// SCCB/I2C target with a small register bank, oversampling SCL/SDA on ILA_clk.
// Answers DEV_ADDR, loads a 16-bit register pointer, accepts writes and serves reads.
module sccb_slave_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned REG_AW   = 4
) (
  input  logic        ILA_clk,
  input  logic        rstn,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_drive_low,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);
  localparam int unsigned NREG = 1 << REG_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_HI, S_ACK_HI, S_REG_LO, S_ACK_LO,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        scl_sr, sda_sr;
  logic [2:0]        cnt, cnt_nxt;
  logic [7:0]        sh;
  logic [15:0]       ptr;
  logic              rw;
  logic [7:0]        bank [NREG];
  logic              drive_nxt;
  logic              do_shift, do_rd_shift, do_rd_ld, do_rw, do_ptr_hi, do_ptr_lo;
  logic              do_wr, do_ptr_inc, busy_set, busy_clr;

  // Stage [1] is the synchronized level, stage [2] its one-cycle-old copy.
  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;
  logic [7:0]        byte_in, rd_byte;
  logic [REG_AW-1:0] idx;

  assign sda_bit   = sda_sr[1];
  assign scl_rise  = scl_sr[1] & ~scl_sr[2];
  assign scl_fall  = ~scl_sr[1] & scl_sr[2];
  assign start_det = scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
  assign stop_det  = scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];
  assign byte_in   = {sh[6:0], sda_bit};
  assign idx       = ptr[REG_AW-1:0];
  assign rd_byte   = bank[idx];

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      scl_sr <= '1;
      sda_sr <= '1;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_i};
      sda_sr <= {sda_sr[1:0], sda_i};
    end
  end

  // ACK states use cnt as a phase flag: 0 = before the 9th SCL rise, 1 = after it.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    drive_nxt   = sda_drive_low;
    do_shift    = 1'b0;
    do_rd_shift = 1'b0;
    do_rd_ld    = 1'b0;
    do_rw       = 1'b0;
    do_ptr_hi   = 1'b0;
    do_ptr_lo   = 1'b0;
    do_wr       = 1'b0;
    do_ptr_inc  = 1'b0;
    busy_set    = 1'b0;
    busy_clr    = 1'b0;
    if (start_det) begin
      state_nxt = S_DEV_ADDR;
      cnt_nxt   = '0;
      drive_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      drive_nxt = 1'b0;
      busy_clr  = 1'b1;
    end else begin
      case (state)
        S_DEV_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
          if (scl_rise) begin
            do_shift = 1'b1;
            cnt_nxt  = cnt + 3'd1;
            if (cnt == 3'd7) begin
              case (state)
                S_DEV_ADDR: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state_nxt = S_DEV_ACK;
                    do_rw     = 1'b1;
                    busy_set  = 1'b1;
                  end else begin
                    state_nxt = S_IGNORE;
                    busy_clr  = 1'b1;
                  end
                end
                S_REG_HI: begin
                  state_nxt = S_ACK_HI;
                  do_ptr_hi = 1'b1;
                end
                S_REG_LO: begin
                  state_nxt = S_ACK_LO;
                  do_ptr_lo = 1'b1;
                end
                default: begin
                  state_nxt = S_WR_ACK;
                  do_wr     = 1'b1;
                end
              endcase
            end
          end
        end
        S_DEV_ACK, S_ACK_HI, S_ACK_LO, S_WR_ACK: begin
          if (scl_rise) begin
            cnt_nxt = 3'd1;
          end else if (scl_fall) begin
            if (cnt == 3'd0) begin
              drive_nxt = 1'b1;
            end else begin
              cnt_nxt   = '0;
              drive_nxt = 1'b0;
              case (state)
                S_DEV_ACK: begin
                  if (rw) begin
                    state_nxt = S_RD_DATA;
                    do_rd_ld  = 1'b1;
                    drive_nxt = ~rd_byte[7];
                  end else begin
                    state_nxt = S_REG_HI;
                  end
                end
                S_ACK_HI: state_nxt = S_REG_LO;
                default:  state_nxt = S_WR_DATA;
              endcase
            end
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            do_rd_shift = 1'b1;
            cnt_nxt     = cnt + 3'd1;
            if (cnt == 3'd7) begin
              state_nxt  = S_RD_ACK;
              do_ptr_inc = 1'b1;
            end
          end else if (scl_fall) begin
            drive_nxt = ~sh[7];
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_bit) state_nxt = S_IGNORE;
            else         cnt_nxt   = 3'd1;
          end else if (scl_fall) begin
            if (cnt == 3'd0) begin
              drive_nxt = 1'b0;
            end else begin
              cnt_nxt   = '0;
              state_nxt = S_RD_DATA;
              do_rd_ld  = 1'b1;
              drive_nxt = ~rd_byte[7];
            end
          end
        end
        default: drive_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      sda_drive_low <= 1'b0;
      sh            <= '0;
      ptr           <= '0;
      rw            <= 1'b0;
      busy          <= 1'b0;
      wr_stb        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      bank          <= '{default: '0};
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sda_drive_low <= drive_nxt;
      wr_stb        <= do_wr;
      if (do_shift)    sh <= byte_in;
      if (do_rd_shift) sh <= {sh[6:0], 1'b0};
      if (do_rd_ld)    sh <= rd_byte;
      if (do_rw)       rw <= byte_in[0];
      if (do_ptr_hi)   ptr[15:8] <= byte_in;
      if (do_ptr_lo)   ptr[7:0]  <= byte_in;
      if (do_wr) begin
        bank[idx] <= byte_in;
        wr_addr   <= ptr;
        wr_data   <= byte_in;
      end
      if (do_wr || do_ptr_inc) ptr <= ptr + 16'd1;
      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
    end
  end
endmodule
